// File: rtl/module_rgb_sequencer_pkg.sv
// Shared definitions for the RGB colour sequencer:
// register map, colour codes and sequencer states.
package pkg_rgb_seq;

  localparam logic [1:0] ADDR_COLOR  = 2'd0;
  localparam logic [1:0] ADDR_DWELL  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    ROJO     = 3'd1,
    VERDE    = 3'd2,
    AZUL     = 3'd3,
    AMARILLO = 3'd4,
    CIAN     = 3'd5,
    MAGENTA  = 3'd6,
    BLANCO   = 3'd7
  } color_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DWELL
  } state_e;

endpackage

// File: rtl/module_rgb_sequencer_if.sv
// CPU register bus of the RGB sequencer.
// Write strobe, address and data in; read data out.
interface module_rgb_sequencer_if;

  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output we_i,
    output addr_i,
    output data_in,
    input  data_out
  );

  modport slave (
    input  we_i,
    input  addr_i,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/module_rgb_sequencer_fifo.sv
// Synchronous FIFO with flush; head reads as zero when empty.
// A push into a full FIFO is accepted only alongside a pop.
module module_fifo_sync #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             clr;

  assign clr     = rst_i || flush;
  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/module_rgb_sequencer.sv
// RGB colour sequencer: plays queued colour codes to the LED
// block, one strobe per colour, spaced by a programmable dwell.
module module_rgb_sequencer
  import pkg_rgb_seq::*;
#(
  parameter int DEPTH     = 8,
  parameter int DWELL_RST = 1000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  module_rgb_sequencer_if.slave         bus,
  output logic                          led_we_o,
  output logic [31:0]                   led_data_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state;
  state_e        state_nx;
  logic [23:0]   dwell_q;
  logic [23:0]   dwell_eff;
  logic [23:0]   cnt_q;
  logic          run_q;
  logic          loop_q;
  logic          ovf_q;
  logic [2:0]    led_q;

  logic          wr_color;
  logic          wr_dwell;
  logic          wr_ctrl;
  logic          wr_status;
  logic          flush;
  logic          run_eff;
  logic          drop;

  logic          fifo_push;
  logic          fifo_pop;
  logic [2:0]    fifo_din;
  logic [2:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          unused_data;

  assign wr_color  = bus.we_i && bus.addr_i == ADDR_COLOR;
  assign wr_dwell  = bus.we_i && bus.addr_i == ADDR_DWELL;
  assign wr_ctrl   = bus.we_i && bus.addr_i == ADDR_CTRL;
  assign wr_status = bus.we_i && bus.addr_i == ADDR_STATUS;
  assign flush     = wr_ctrl && bus.data_in[2];
  assign run_eff   = wr_ctrl ? bus.data_in[0] : run_q;
  assign dwell_eff = (dwell_q == '0) ? 24'd1 : dwell_q;
  assign unused_data = ^bus.data_in[31:24];

  module_fifo_sync #(
    .WIDTH (3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    fifo_pop  = 1'b0;
    fifo_push = wr_color;
    fifo_din  = bus.data_in[2:0];
    drop      = wr_color && full;
    led_we_o  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (run_q && !empty) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        led_we_o = 1'b1;
        fifo_pop = 1'b1;
        state_nx = ST_DWELL;
        // Rotation owns the push port; a CPU push loses.
        if (loop_q) begin
          fifo_push = 1'b1;
          fifo_din  = head;
          drop      = wr_color;
        end else begin
          drop      = 1'b0;
        end
      end
      ST_DWELL: begin
        if (!run_eff)            state_nx = ST_IDLE;
        else if (cnt_q == '0)    state_nx = empty ? ST_IDLE
                                                  : ST_LOAD;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
    if (rst_i) led_we_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      dwell_q <= 24'(DWELL_RST);
      run_q   <= 1'b0;
      loop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      if (state == ST_LOAD) begin
        cnt_q <= dwell_eff - 24'd1;
        led_q <= head;
      end else if (state == ST_DWELL && cnt_q != '0) begin
        cnt_q <= cnt_q - 24'd1;
      end
      if (wr_dwell) dwell_q <= bus.data_in[23:0];
      if (wr_ctrl) begin
        run_q  <= bus.data_in[0];
        loop_q <= bus.data_in[1];
      end
      if (wr_status) ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
    end
  end

  assign led_data_o = {29'b0, (state == ST_LOAD) ? head : led_q};

  always_comb begin
    bus.data_out = '0;
    unique case (bus.addr_i)
      ADDR_COLOR:  bus.data_out = {29'b0, head};
      ADDR_DWELL:  bus.data_out = {8'b0, dwell_q};
      ADDR_CTRL:   bus.data_out = {30'b0, loop_q, run_q};
      ADDR_STATUS: bus.data_out = {23'b0, state != ST_IDLE,
                                   ovf_q, full, empty,
                                   5'(count)};
      default:     bus.data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_module_rgb_sequencer.sv
// Self-checking bench for module_rgb_sequencer against a
// queue-based model of the colour FIFO and strobe timing.
module tb_module_rgb_sequencer;
  import pkg_rgb_seq::*;

  localparam int DEPTH     = 8;
  localparam int DWELL_RST = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        led_we;
  logic [31:0] led_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int st_cyc[$];
  int st_dat[$];
  int mq[$];
  int stim[$];
  bit movf;

  module_rgb_sequencer_if bus ();

  module_rgb_sequencer #(
    .DEPTH     (DEPTH),
    .DWELL_RST (DWELL_RST)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .led_we_o   (led_we),
    .led_data_o (led_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (led_we === 1'b1) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(int'(led_data));
    end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input int d);
    bus.we_i = 1'b1; bus.addr_i = a; bus.data_in = d;
    @(negedge clk);
    bus.we_i = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr_i = a;
    #1;
    d = bus.data_out;
  endtask

  function automatic void model_push(input int c);
    if (mq.size() < DEPTH) mq.push_back(c);
    else movf = 1'b1;
  endfunction

  function automatic logic [31:0] exp_status(input bit busy);
    int n;
    n = mq.size();
    return 32'(n) | ((n == 0) ? 32'h20 : 32'h0)
         | ((n == DEPTH) ? 32'h40 : 32'h0)
         | (movf ? 32'h80 : 32'h0) | (busy ? 32'h100 : 32'h0);
  endfunction

  task automatic cleanup();
    wr(ADDR_CTRL, 0); wr(ADDR_CTRL, 4); wr(ADDR_STATUS, 0);
    mq.delete(); stim.delete(); movf = 1'b0;
    st_cyc.delete(); st_dat.delete();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_in = '0;
    idle(3);
    rst = 1'b0;
    checks++; if (led_we !== 1'b0) begin errors++;
      $display("FAIL reset_led_we: got %b expected 0", led_we); end
    checks++; if (led_data !== 32'h0) begin errors++;
      $display("FAIL reset_led_data: got %h expected 0", led_data); end
    rd(ADDR_STATUS, v);
    checks++; if (v !== 32'h20) begin errors++;
      $display("FAIL reset_status: got %h expected 20", v); end
    rd(ADDR_DWELL, v);
    checks++; if (v !== 32'(DWELL_RST)) begin errors++;
      $display("FAIL reset_dwell: got %0d expected %0d", v, DWELL_RST); end
    rd(ADDR_CTRL, v);
    checks++; if (v !== 32'h0) begin errors++;
      $display("FAIL reset_ctrl: got %h expected 0", v); end
    rd(ADDR_COLOR, v);
    checks++; if (v !== 32'h0) begin errors++;
      $display("FAIL reset_color: got %h expected 0", v); end
    idle(1);
  endtask

  // Strobes at w+2 + k*(max(D,1)+1) until run is cleared in cycle c.
  task automatic test_sequence(input string tag, input int d,
                               input bit lp, input int window);
    int w, c, eff, n, k;
    int exp_t[$];
    int exp_d[$];
    logic [31:0] v;
    st_cyc.delete(); st_dat.delete();
    wr(ADDR_DWELL, d);
    foreach (stim[i]) begin
      wr(ADDR_COLOR, stim[i]); model_push(stim[i]);
    end
    n = mq.size();
    eff = (d == 0) ? 1 : d;
    w = cyc;
    wr(ADDR_CTRL, 1 + 2 * int'(lp));
    idle(window);
    c = cyc;
    wr(ADDR_CTRL, 2 * int'(lp));
    idle(4);
    k = 0;
    while (w + 2 + k * (eff + 1) <= c && (lp || k < n)) begin
      exp_t.push_back(w + 2 + k * (eff + 1));
      exp_d.push_back(mq[lp ? k % n : k]);
      k++;
    end
    repeat (k) begin
      if (lp) mq.push_back(mq.pop_front());
      else void'(mq.pop_front());
    end
    checks++; if (st_cyc.size() != exp_t.size()) begin errors++;
      $display("FAIL %s_count: got %0d expected %0d", tag,
               st_cyc.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size() && i < st_cyc.size(); i++) begin
      checks++;
      if (st_cyc[i] != exp_t[i] || st_dat[i] != exp_d[i]) begin
        errors++;
        $display("FAIL %s_strobe%0d: got cyc %0d col %0d expected cyc %0d col %0d",
                 tag, i, st_cyc[i], st_dat[i], exp_t[i], exp_d[i]);
      end
    end
    rd(ADDR_STATUS, v);
    checks++; if (v !== exp_status(1'b0)) begin errors++;
      $display("FAIL %s_status: got %h expected %h", tag, v,
               exp_status(1'b0)); end
    cleanup();
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    for (int i = 0; i <= DEPTH; i++) stim.push_back($urandom_range(0, 7));
    foreach (stim[i]) begin
      wr(ADDR_COLOR, stim[i]); model_push(stim[i]);
    end
    rd(ADDR_STATUS, v);
    checks++; if (v !== exp_status(1'b0)) begin errors++;
      $display("FAIL ovf_status: got %h expected %h", v, exp_status(1'b0)); end
    rd(ADDR_COLOR, v);
    checks++; if (v !== 32'(mq[0])) begin errors++;
      $display("FAIL ovf_head: got %0d expected %0d", v, mq[0]); end
    wr(ADDR_CTRL, 4); mq.delete();
    rd(ADDR_STATUS, v);
    checks++; if (v !== exp_status(1'b0)) begin errors++;
      $display("FAIL ovf_flush: got %h expected %h", v, exp_status(1'b0)); end
    wr(ADDR_STATUS, 0); movf = 1'b0;
    rd(ADDR_STATUS, v);
    checks++; if (v !== 32'h20) begin errors++;
      $display("FAIL ovf_clear: got %h expected 20", v); end
    cleanup();
  endtask

  task automatic test_collide(input bit lp);
    logic [31:0] v;
    int nc, extra;
    nc = lp ? 2 : DEPTH;
    for (int i = 0; i < nc; i++) begin
      stim.push_back($urandom_range(0, 7));
      wr(ADDR_COLOR, stim[i]); model_push(stim[i]);
    end
    extra = $urandom_range(0, 7);
    wr(ADDR_DWELL, 20);
    wr(ADDR_CTRL, 1 + 2 * int'(lp));
    idle(1);
    wr(ADDR_COLOR, extra);
    wr(ADDR_CTRL, 2 * int'(lp));
    if (lp) begin
      mq.push_back(mq.pop_front()); movf = 1'b1;
    end else begin
      void'(mq.pop_front()); mq.push_back(extra);
    end
    rd(ADDR_STATUS, v);
    checks++; if (v !== exp_status(1'b0)) begin errors++;
      $display("FAIL collide%0d_status: got %h expected %h", lp, v,
               exp_status(1'b0)); end
    rd(ADDR_COLOR, v);
    checks++; if (v !== 32'(mq[0])) begin errors++;
      $display("FAIL collide%0d_head: got %0d expected %0d", lp, v, mq[0]); end
    cleanup();
  endtask

  // mode 0: clear run, 1: flush, 2: reset, three cycles after a strobe.
  task automatic test_abort(input int mode);
    logic [31:0] v;
    bit found;
    int first;
    for (int i = 0; i < 3; i++) begin
      stim.push_back($urandom_range(1, 7));
      wr(ADDR_COLOR, stim[i]); model_push(stim[i]);
    end
    wr(ADDR_DWELL, 10);
    wr(ADDR_CTRL, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = (led_we === 1'b1);
    end
    checks++; if (!found) begin errors++;
      $display("FAIL abort%0d_first: got no strobe expected one", mode); end
    first = mq.pop_front();
    idle(3);
    if (mode == 2) begin
      rst = 1'b1;
      @(negedge clk);
      checks++; if (led_we !== 1'b0 || led_data !== 32'h0) begin errors++;
        $display("FAIL rst_outputs: got %b/%h expected 0/0", led_we, led_data); end
      rd(ADDR_DWELL, v);
      checks++; if (v !== 32'(DWELL_RST)) begin errors++;
        $display("FAIL rst_dwell: got %0d expected %0d", v, DWELL_RST); end
      rd(ADDR_CTRL, v);
      checks++; if (v !== 32'h0) begin errors++;
        $display("FAIL rst_ctrl: got %h expected 0", v); end
      rst = 1'b0;
      mq.delete();
    end else if (mode == 1) begin
      wr(ADDR_CTRL, 5); mq.delete();
      rd(ADDR_CTRL, v);
      checks++; if (v !== 32'h1) begin errors++;
        $display("FAIL flush_ctrl: got %h expected 1", v); end
    end else begin
      wr(ADDR_CTRL, 0);
    end
    rd(ADDR_STATUS, v);
    checks++; if (v !== exp_status(1'b0)) begin errors++;
      $display("FAIL abort%0d_status: got %h expected %h", mode, v,
               exp_status(1'b0)); end
    idle(25);
    checks++; if (st_cyc.size() != 1) begin errors++;
      $display("FAIL abort%0d_strobes: got %0d expected 1", mode,
               st_cyc.size()); end
    checks++;
    if (led_data !== ((mode == 2) ? 32'h0 : 32'(first))) begin errors++;
      $display("FAIL abort%0d_hold: got %0d expected %0d", mode, led_data,
               (mode == 2) ? 0 : first); end
    cleanup();
  endtask

  initial begin
    bus.we_i = 1'b0; bus.addr_i = '0; bus.data_in = '0;
    @(negedge clk);
    test_reset();
    cleanup();
    stim = {ROJO, VERDE, AZUL};
    test_sequence("basic", 4, 1'b0, 30);
    stim = {CIAN, MAGENTA};
    test_sequence("loop", 2, 1'b1, 20);
    stim = {BLANCO, AZUL, AMARILLO, ROJO};
    test_sequence("dwell_zero", 0, 1'b0, 12);
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) stim.push_back($urandom_range(0, 7));
      test_sequence("random", $urandom_range(0, 5),
                    1'($urandom_range(0, 1)), $urandom_range(5, 40));
    end
    test_overflow();
    test_collide(1'b0);
    test_collide(1'b1);
    test_abort(0);
    test_abort(1);
    test_abort(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
